// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: keeps a current and a next I-cache line, presents a
// 32-byte window to the bundle-extract stage and walks the pc by reported bundle sizes.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          LINE_BYTES = 32
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirectAddr_i,
    output logic                      icReq_o,
    output logic [26:0]               icLineAddr_o,
    input  logic                      icValid_i,
    input  logic [8*LINE_BYTES-1:0]   icLine_i,
    output logic                      stageEnable_o,
    output logic [4:0]                byteAddr_o,
    output logic [8*LINE_BYTES-1:0]   block_o,
    input  logic                      advValid_i,
    input  logic [3:0]                advBytes_i,
    output logic [31:0]               pc_o,
    output logic                      sizeError_o
);

    localparam int HALF = LINE_BYTES / 2;

    typedef enum logic [2:0] {
        FETCH_CUR,
        FETCH_NXT,
        ISSUE,
        WAIT_ADV,
        DRAIN
    } state_t;

    state_t                    r_state, w_state_next;
    logic [31:0]               r_pc, w_pc_next;
    logic                      r_cur_valid, w_cur_valid_next;
    logic [26:0]               r_cur_tag, w_cur_tag_next;
    logic [8*LINE_BYTES-1:0]   r_cur_data, w_cur_data_next;
    logic                      r_nxt_valid, w_nxt_valid_next;
    logic [26:0]               r_nxt_tag, w_nxt_tag_next;
    logic [8*LINE_BYTES-1:0]   r_nxt_data, w_nxt_data_next;
    logic                      r_ic_req, w_ic_req_next;
    logic [26:0]               r_ic_addr, w_ic_addr_next;
    logic                      r_size_err, w_size_err_next;

    logic                      w_ic_ack;
    logic                      w_straddle;
    logic [26:0]               w_pc_tag_inc;
    logic [26:0]               w_cur_tag_inc;
    logic                      w_nxt_ready;
    logic [31:0]               w_pc_adv;
    logic [26:0]               w_adv_tag;
    logic                      w_adv_straddle;
    logic                      w_size_ok;
    logic                      w_presenting;
    logic [8*LINE_BYTES-1:0]   w_split;

    // A response only counts while our request is actually up.
    assign w_ic_ack       = icValid_i & r_ic_req;
    assign w_straddle     = (r_pc[4:0] > 5'd24);
    assign w_pc_tag_inc   = r_pc[31:5] + 27'd1;
    assign w_cur_tag_inc  = r_cur_tag + 27'd1;
    assign w_nxt_ready    = r_nxt_valid && (r_nxt_tag == w_cur_tag_inc);
    assign w_pc_adv       = r_pc + {28'd0, advBytes_i};
    assign w_adv_tag      = w_pc_adv[31:5];
    assign w_adv_straddle = (w_pc_adv[4:0] > 5'd24);
    assign w_size_ok      = (advBytes_i == 4'd5) || (advBytes_i == 4'd7) || (advBytes_i == 4'd8);

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_cur_valid_next = r_cur_valid;
        w_cur_tag_next   = r_cur_tag;
        w_cur_data_next  = r_cur_data;
        w_nxt_valid_next = r_nxt_valid;
        w_nxt_tag_next   = r_nxt_tag;
        w_nxt_data_next  = r_nxt_data;
        w_size_err_next  = r_size_err;

        case (r_state)
            FETCH_CUR: begin
                if (w_ic_ack) begin
                    w_cur_valid_next = 1'b1;
                    w_cur_tag_next   = r_pc[31:5];
                    w_cur_data_next  = icLine_i;
                    if (w_straddle && !(r_nxt_valid && (r_nxt_tag == w_pc_tag_inc)))
                        w_state_next = FETCH_NXT;
                    else
                        w_state_next = ISSUE;
                end
            end
            FETCH_NXT: begin
                if (w_ic_ack) begin
                    w_nxt_valid_next = 1'b1;
                    w_nxt_tag_next   = w_cur_tag_inc;
                    w_nxt_data_next  = icLine_i;
                    w_state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (enable_i)
                    w_state_next = WAIT_ADV;
            end
            WAIT_ADV: begin
                if (advValid_i) begin
                    w_pc_next = w_pc_adv;
                    if (!w_size_ok)
                        w_size_err_next = 1'b1;
                    if (r_cur_valid && (w_adv_tag == r_cur_tag)) begin
                        w_state_next = (w_adv_straddle && !w_nxt_ready) ? FETCH_NXT : ISSUE;
                    end else if (r_nxt_valid && (w_adv_tag == r_nxt_tag)) begin
                        // Walked into the next line: promote it, the new nxt is unknown.
                        w_cur_valid_next = 1'b1;
                        w_cur_tag_next   = r_nxt_tag;
                        w_cur_data_next  = r_nxt_data;
                        w_nxt_valid_next = 1'b0;
                        w_state_next     = w_adv_straddle ? FETCH_NXT : ISSUE;
                    end else begin
                        w_state_next = FETCH_CUR;
                    end
                end
            end
            DRAIN: begin
                if (w_ic_ack)
                    w_state_next = FETCH_CUR;
            end
            default: w_state_next = FETCH_CUR;
        endcase

        if (redirect_i) begin
            w_pc_next        = redirectAddr_i;
            w_cur_valid_next = 1'b0;
            w_nxt_valid_next = 1'b0;
            w_size_err_next  = r_size_err;
            case (r_state)
                // A live request must be drained unless its data arrives right now.
                FETCH_CUR, FETCH_NXT:
                    w_state_next = (r_ic_req && !icValid_i) ? DRAIN : FETCH_CUR;
                DRAIN:
                    w_state_next = w_ic_ack ? FETCH_CUR : DRAIN;
                default:
                    w_state_next = FETCH_CUR;
            endcase
        end
    end

    always_comb begin
        w_ic_req_next  = 1'b0;
        w_ic_addr_next = r_ic_addr;
        case (w_state_next)
            FETCH_CUR: begin
                w_ic_req_next  = 1'b1;
                w_ic_addr_next = w_pc_next[31:5];
            end
            FETCH_NXT: begin
                w_ic_req_next  = 1'b1;
                w_ic_addr_next = w_cur_tag_next + 27'd1;
            end
            DRAIN: begin
                w_ic_req_next  = 1'b1;
                w_ic_addr_next = r_ic_addr;
            end
            default: begin
                w_ic_req_next  = 1'b0;
                w_ic_addr_next = r_ic_addr;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= FETCH_CUR;
            r_pc        <= RESET_PC;
            r_cur_valid <= 1'b0;
            r_cur_tag   <= '0;
            r_cur_data  <= '0;
            r_nxt_valid <= 1'b0;
            r_nxt_tag   <= '0;
            r_nxt_data  <= '0;
            r_ic_req    <= 1'b0;
            r_ic_addr   <= '0;
            r_size_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_cur_valid <= w_cur_valid_next;
            r_cur_tag   <= w_cur_tag_next;
            r_cur_data  <= w_cur_data_next;
            r_nxt_valid <= w_nxt_valid_next;
            r_nxt_tag   <= w_nxt_tag_next;
            r_nxt_data  <= w_nxt_data_next;
            r_ic_req    <= w_ic_req_next;
            r_ic_addr   <= w_ic_addr_next;
            r_size_err  <= w_size_err_next;
        end
    end

    // Straddling window: upper half of cur followed by lower half of nxt.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_win
            if (gi < HALF) begin : g_lo
                assign w_split[gi*8 +: 8] = r_cur_data[(gi+HALF)*8 +: 8];
            end else begin : g_hi
                assign w_split[gi*8 +: 8] = r_nxt_data[(gi-HALF)*8 +: 8];
            end
        end
    endgenerate

    assign w_presenting  = (r_state == ISSUE) || (r_state == WAIT_ADV);
    assign block_o       = w_presenting ? (w_straddle ? w_split : r_cur_data) : '0;
    assign byteAddr_o    = w_presenting ? (w_straddle ? (r_pc[4:0] - 5'd16) : r_pc[4:0]) : 5'd0;
    assign stageEnable_o = (r_state == ISSUE) && enable_i && !redirect_i;
    assign icReq_o       = r_ic_req;
    assign icLineAddr_o  = r_ic_addr;
    assign pc_o          = r_pc;
    assign sizeError_o   = r_size_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an I-cache responder model plus expected
// request and issue queues filled as stimulus is driven.
module tb_fetch_sequencer;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         enable_i;
    logic         redirect_i;
    logic [31:0]  redirectAddr_i;
    logic         icReq_o;
    logic [26:0]  icLineAddr_o;
    logic         icValid_i;
    logic [255:0] icLine_i;
    logic         stageEnable_o;
    logic [4:0]   byteAddr_o;
    logic [255:0] block_o;
    logic         advValid_i;
    logic [3:0]   advBytes_i;
    logic [31:0]  pc_o;
    logic         sizeError_o;

    always #5 clock_i = ~clock_i;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .LINE_BYTES(32)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .redirect_i     (redirect_i),
        .redirectAddr_i (redirectAddr_i),
        .icReq_o        (icReq_o),
        .icLineAddr_o   (icLineAddr_o),
        .icValid_i      (icValid_i),
        .icLine_i       (icLine_i),
        .stageEnable_o  (stageEnable_o),
        .byteAddr_o     (byteAddr_o),
        .block_o        (block_o),
        .advValid_i     (advValid_i),
        .advBytes_i     (advBytes_i),
        .pc_o           (pc_o),
        .sizeError_o    (sizeError_o)
    );

    typedef struct {
        logic [31:0]  pc;
        logic [4:0]   ba;
        logic [255:0] blk;
    } issue_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ic_lat = 3;
    bit          ic_stall = 1'b0;
    logic [31:0] model_pc;
    logic [26:0] exp_req[$];
    issue_t      sb_issue[$];

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [26:0] tag);
        logic [255:0] l;
        int v;
        l = '0;
        for (int k = 0; k < 32; k++) begin
            v = int'(tag[7:0]) * 29 + int'(tag[15:8]) + k * 11 + 60;
            l[k*8 +: 8] = v[7:0];
        end
        return l;
    endfunction

    function automatic void push_issue(input logic [31:0] pc);
        issue_t e;
        logic [255:0] a, b;
        a = line_of(pc[31:5]);
        b = line_of(pc[31:5] + 27'd1);
        e.pc = pc;
        if (pc[4:0] > 5'd24) begin
            e.blk = {b[127:0], a[255:128]};
            e.ba  = pc[4:0] - 5'd16;
        end else begin
            e.blk = a;
            e.ba  = pc[4:0];
        end
        sb_issue.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic wait_issue();
        for (int i = 0; i < 80 && sb_issue.size() != 0; i++) tick();
        check_eq("issue_arrived_pending", sb_issue.size(), 0);
    endtask

    task automatic adv(input logic [3:0] b);
        model_pc = model_pc + {28'd0, b};
        push_issue(model_pc);
        advValid_i = 1'b1;
        advBytes_i = b;
        tick();
        advValid_i = 1'b0;
        advBytes_i = 4'd0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        model_pc       = a;
        redirect_i     = 1'b1;
        redirectAddr_i = a;
        tick();
        redirect_i     = 1'b0;
    endtask

    // I-cache responder: answers each request after ic_lat cycles unless stalled.
    initial begin : icache
        int cnt;
        logic [26:0] exp_addr;
        cnt = 0;
        exp_addr = '0;
        icValid_i = 1'b0;
        icLine_i = '0;
        forever begin
            @(posedge clock_i);
            #1;
            if (icValid_i) begin
                icValid_i = 1'b0;
                cnt = 0;
            end else if (reset_i !== 1'b0 || icReq_o !== 1'b1) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    $display("request line=%0h", icLineAddr_o);
                    if (exp_req.size() == 0) begin
                        check_eq("unexpected_request", 1, 0);
                        exp_addr = icLineAddr_o;
                    end else begin
                        exp_addr = exp_req.pop_front();
                        check_eq("request_line", icLineAddr_o, exp_addr);
                    end
                end else begin
                    check_eq("request_held", icLineAddr_o, exp_addr);
                end
                if (cnt >= ic_lat && !ic_stall) begin
                    icValid_i = 1'b1;
                    icLine_i  = line_of(exp_addr);
                end
            end
        end
    end

    initial begin : monitor
        issue_t e;
        forever begin
            @(negedge clock_i);
            if (reset_i === 1'b0 && stageEnable_o === 1'b1) begin
                $display("issue pc=%h byteAddr=%0d", pc_o, byteAddr_o);
                if (sb_issue.size() == 0) begin
                    check_eq("stray_stage_enable", 1, 0);
                end else begin
                    e = sb_issue.pop_front();
                    check_eq("issue_pc", pc_o, e.pc);
                    check_eq("issue_byteAddr", byteAddr_o, e.ba);
                    check_eq("issue_block", block_o, e.blk);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset_i        = 1'b1;
        enable_i       = 1'b1;
        redirect_i     = 1'b0;
        redirectAddr_i = '0;
        advValid_i     = 1'b0;
        advBytes_i     = '0;
        model_pc       = 32'h0;
        repeat (3) tick();
        check_eq("rst_icReq", icReq_o, 0);
        check_eq("rst_stageEnable", stageEnable_o, 0);
        check_eq("rst_sizeError", sizeError_o, 0);
        check_eq("rst_byteAddr", byteAddr_o, 0);
        check_eq("rst_block", block_o, 0);
        check_eq("rst_pc", pc_o, 32'h0);

        // First fetch of line 0, then three 8-byte bundles in the same line.
        exp_req.push_back(27'd0);
        push_issue(32'h0);
        reset_i = 1'b0;
        tick();
        check_eq("first_req_after_reset", icReq_o, 1);
        check_eq("first_req_line", icLineAddr_o, 0);
        wait_issue();
        for (int i = 0; i < 3; i++) begin
            adv(4'd8);
            wait_issue();
        end

        // Redirect to a straddling pc: lines 0 and 1 fetched in order.
        exp_req.push_back(27'd0);
        exp_req.push_back(27'd1);
        push_issue(32'h1A);
        redirect_to(32'h1A);
        wait_issue();
        adv(4'd7);
        wait_issue();
        adv(4'd7);
        wait_issue();
        adv(4'd8);
        wait_issue();
        adv(4'd8);
        wait_issue();
        exp_req.push_back(27'd2);
        adv(4'd5);
        wait_issue();
        check_eq("size_ok_no_error", sizeError_o, 0);
        adv(4'd7);
        wait_issue();

        // Issue held off while enable_i is low, pulse on the cycle it rises.
        enable_i = 1'b0;
        adv(4'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("held_stageEnable", stageEnable_o, 0);
        end
        check_eq("held_pending", sb_issue.size(), 1);
        enable_i = 1'b1;
        tick();
        check_eq("pulse_on_enable_pending", sb_issue.size(), 0);

        // Illegal bundle size: sticky error, pc still advances.
        adv(4'd6);
        check_eq("size_error_set", sizeError_o, 1);
        wait_issue();
        repeat (3) tick();
        check_eq("size_error_sticky", sizeError_o, 1);

        // Reset in the middle of a stalled handshake.
        ic_stall = 1'b1;
        exp_req.push_back(27'd4);
        redirect_to(32'h80);
        repeat (3) tick();
        reset_i = 1'b1;
        #1;
        check_eq("midreset_icReq", icReq_o, 0);
        check_eq("midreset_sizeError", sizeError_o, 0);
        check_eq("midreset_pc", pc_o, 32'h0);
        repeat (2) tick();
        exp_req.push_back(27'd0);
        reset_i = 1'b0;
        repeat (2) tick();

        // Redirect while line 0 is outstanding: drain it, then fetch the new target.
        redirect_to(32'h100);
        check_eq("drain_pc", pc_o, 32'h100);
        check_eq("drain_req_held", icReq_o, 1);
        check_eq("drain_line_held", icLineAddr_o, 0);
        redirect_to(32'h120);
        check_eq("drain_redirect_pc", pc_o, 32'h120);
        check_eq("drain_line_still_old", icLineAddr_o, 0);
        exp_req.push_back(27'd9);
        push_issue(32'h120);
        ic_stall = 1'b0;
        wait_issue();

        repeat (4) tick();
        check_eq("req_queue_drained", exp_req.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the byte address fetched first after reset.
REQ-002 Parameter LINE_BYTES, default 32, SHALL be the I-cache line size; only 32 is supported.
REQ-003 clock_i  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 enable_i  in  1  issue permit; when 0, no new bundle issue begins.
REQ-006 redirect_i  in  1  branch/exception redirect strobe.
REQ-007 redirectAddr_i  in  32  byte address to redirect to.
REQ-008 icReq_o  out  1  line request to the I-cache.
REQ-009 icLineAddr_o  out  27  requested line address, equal to byte address bits [31:5].
REQ-010 icValid_i  in  1  I-cache response valid; completes the outstanding request.
REQ-011 icLine_i  in  256  returned line, byte 0 at bits [0:7].
REQ-012 stageEnable_o  out  1  one-cycle enable to the bundle-extract stage.
REQ-013 byteAddr_o  out  5  byte offset of the bundle within block_o.
REQ-014 block_o  out  256  window presented to the extract stage.
REQ-015 advValid_i  in  1  extract stage reports bundle size.
REQ-016 advBytes_i  in  4  bundle size in bytes; legal values 5, 7, 8.
REQ-017 pc_o  out  32  byte address of the bundle currently issued or awaited.
REQ-018 sizeError_o  out  1  sticky illegal-size flag.

Function
REQ-019 The FSM SHALL use states FETCH_CUR, FETCH_NXT, ISSUE, WAIT_ADV and DRAIN.
REQ-020 Handshake: icReq_o and icLineAddr_o SHALL remain high and stable from assertion until icValid_i=1 is sampled; icValid_i with icReq_o=0 SHALL be ignored.
REQ-021 The sequencer SHALL hold two line buffers, cur and nxt, each with a valid bit and a 27-bit tag.
REQ-022 A bundle is straddling iff pc[4:0] > 24.
REQ-023 FETCH_CUR SHALL request tag pc[31:5], load cur on icValid_i, then go to FETCH_NXT if straddling and nxt does not hold tag+1, else to ISSUE.
REQ-024 FETCH_NXT SHALL request tag cur.tag+1 (27-bit wrap), load nxt on icValid_i, then go to ISSUE.
REQ-025 In ISSUE, when enable_i=1, the sequencer SHALL assert stageEnable_o for exactly one cycle and go to WAIT_ADV; when enable_i=0 it SHALL remain in ISSUE with stageEnable_o=0.
REQ-026 When not straddling: block_o = cur and byteAddr_o = pc[4:0].
REQ-027 When straddling: block_o = cur bytes 16..31 followed by nxt bytes 0..15, and byteAddr_o = pc[4:0] - 16.
REQ-028 block_o and byteAddr_o SHALL be stable from the ISSUE cycle until leaving WAIT_ADV.
REQ-029 In WAIT_ADV, on advValid_i=1 the sequencer SHALL set pc <= pc + advBytes_i (32-bit wrap).
REQ-030 Next state after WAIT_ADV SHALL be chosen from the new pc as follows.
  - New tag == cur.tag: ISSUE, or FETCH_NXT if straddling and nxt is stale.
  - New tag == nxt.tag: nxt moves into cur and nxt is invalidated (same cycle), then REQ-023 rules apply without a re-request of cur.
  - Otherwise: FETCH_CUR.
REQ-031 advBytes_i not in {5, 7, 8} SHALL set sizeError_o, which clears only on reset; the pc SHALL still advance by the given value.
REQ-032 Redirect priority:
  - redirect_i SHALL override every other transition.
  - Effects: pc <= redirectAddr_i; cur and nxt invalidated; stageEnable_o=0 next cycle.
  - No request outstanding: go to FETCH_CUR.
  - Request outstanding (FETCH_CUR/FETCH_NXT): go to DRAIN.
REQ-033 DRAIN SHALL keep icReq_o high at the old address until icValid_i, discard the returned data, then go to FETCH_CUR.
REQ-034 redirect_i in DRAIN SHALL update pc only.
REQ-035 redirect_i in the same cycle as icValid_i SHALL discard that data and go to FETCH_CUR.
REQ-036 advValid_i outside WAIT_ADV SHALL be ignored.

Reset
REQ-037 While reset_i=1 the block SHALL be in the following state:
  - FSM = FETCH_CUR; pc = RESET_PC.
  - cur and nxt invalid.
  - icReq_o, stageEnable_o and sizeError_o = 0.
  - byteAddr_o = 0; block_o = 0.
REQ-038 The first request SHALL be issued in the first cycle after reset_i deasserts.
REQ-039 Reset mid-handshake SHALL abandon the request with no drain.

Verification
REQ-040 Scenario: reset, RESET_PC=0, line 0 returned after 3 cycles -> icLineAddr_o=0; one stageEnable_o pulse with byteAddr_o=0, block_o=line0.
REQ-041 Scenario: advBytes 8,8,8 from pc=0 -> issues at byteAddr_o 8, 16, 24 with no new icReq_o.
REQ-042 Scenario: pc=0x1A -> lines 0 and 1 fetched in order; block_o = line0[16:31]+line1[0:15]; byteAddr_o=10; advBytes=7 gives pc=0x21 with no refetch and byteAddr_o=1.
REQ-043 Scenario: redirect_i to 0x100 while FETCH_CUR is waiting on line 0 -> DRAIN; line 0 response discarded; next icLineAddr_o=8; no stale stageEnable_o.
REQ-044 Scenario: enable_i=0 in ISSUE for 5 cycles -> stageEnable_o stays 0; the pulse occurs the cycle enable_i rises.
REQ-045 Scenario: advBytes_i=6 -> sizeError_o=1 from the next cycle until reset.
